// File: rtl/swan_pkg.sv
// Shared sizes, default rotate amounts, FSM encoding and the column rotate
// helper for the SWAN64 serial round controller.
package swan_pkg;

    localparam int BLOCK_SIZE  = 64;
    localparam int SIDE_SIZE   = BLOCK_SIZE / 2;
    localparam int COLUMN_SIZE = SIDE_SIZE / 4;

    localparam int DEF_ROUNDS = 32;
    localparam int DEF_PA     = 1;
    localparam int DEF_PB     = 2;
    localparam int DEF_PC     = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index 0 is the MSB, so a right rotate moves bits toward higher indices.
    function automatic logic [0:COLUMN_SIZE-1] rotr(input logic [0:COLUMN_SIZE-1] a,
                                                    input int p);
        rotr = (a >> p) | (a << (COLUMN_SIZE - p));
    endfunction

endpackage

// File: rtl/swan_theta_key.sv
// Theta-key linear layer: per-column right rotates of x, then XOR with the round key.
module swan_theta_key
    import swan_pkg::*;
#(
    parameter int PA = DEF_PA,
    parameter int PB = DEF_PB,
    parameter int PC = DEF_PC
) (
    input  logic [0:SIDE_SIZE-1] x,
    input  logic [0:SIDE_SIZE-1] rk,
    output logic [0:SIDE_SIZE-1] y
);

    // Column 0 sits at the MSB end; column 3 passes through unrotated.
    assign y[0*COLUMN_SIZE +: COLUMN_SIZE] = rotr(x[0*COLUMN_SIZE +: COLUMN_SIZE], PC)
                                             ^ rk[0*COLUMN_SIZE +: COLUMN_SIZE];
    assign y[1*COLUMN_SIZE +: COLUMN_SIZE] = rotr(x[1*COLUMN_SIZE +: COLUMN_SIZE], PB)
                                             ^ rk[1*COLUMN_SIZE +: COLUMN_SIZE];
    assign y[2*COLUMN_SIZE +: COLUMN_SIZE] = rotr(x[2*COLUMN_SIZE +: COLUMN_SIZE], PA)
                                             ^ rk[2*COLUMN_SIZE +: COLUMN_SIZE];
    assign y[3*COLUMN_SIZE +: COLUMN_SIZE] = x[3*COLUMN_SIZE +: COLUMN_SIZE]
                                             ^ rk[3*COLUMN_SIZE +: COLUMN_SIZE];

endmodule

// File: rtl/swan64_serial_round_ctrl.sv
// SWAN64 serial round sequencer: load a block, run ROUNDS key-fed rounds
// (stalling on missing keys), then hold the result until it is taken.
module swan64_serial_round_ctrl
    import swan_pkg::*;
#(
    parameter int  ROUNDS = DEF_ROUNDS,
    parameter int  PA     = DEF_PA,
    parameter int  PB     = DEF_PB,
    parameter int  PC     = DEF_PC,
    localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:BLOCK_SIZE-1] din,
    output logic                  rk_req,
    output logic [RW-1:0]         rk_round,
    input  logic [0:SIDE_SIZE-1]  rk,
    input  logic                  rk_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:BLOCK_SIZE-1] dout,
    output state_t                fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // (or rk_req and rk_valid) are both high; ready/req/out_valid come from state only.

    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

    state_t               state, state_next;
    logic [RW-1:0]        rnd;
    logic [0:SIDE_SIZE-1] l_q, r_q, t;

    swan_theta_key #(.PA(PA), .PB(PB), .PC(PC)) u_theta (
        .x  (r_q),
        .rk (rk),
        .y  (t)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rnd   <= '0;
            l_q   <= '0;
            r_q   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && in_valid) begin
                l_q <= din[0:SIDE_SIZE-1];
                r_q <= din[SIDE_SIZE:BLOCK_SIZE-1];
                rnd <= '0;
            end else if (state == ROUND && rk_valid) begin
                l_q <= r_q;
                r_q <= l_q ^ t;
                // Holding at the last index keeps rnd within range until the next load.
                if (rnd != LAST) rnd <= rnd + RW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ROUND;
            ROUND:   if (rk_valid && rnd == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign rk_req    = (state == ROUND);
    assign out_valid = (state == DONE);
    assign rk_round  = rnd;
    assign dout      = {l_q, r_q};
    assign fsm_state = state;

endmodule

// File: tb/tb_swan64_serial_round_ctrl.sv
// Directed bench for the SWAN64 round controller: a 1-round and a 32-round instance.
module tb_swan64_serial_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ROUNDS=1 instance
    logic        in_valid1 = 1'b0, rk_valid1 = 1'b0, out_ready1 = 1'b1;
    logic [63:0] din1 = '0;
    logic [31:0] rk1 = '0;
    logic        in_ready1, rk_req1, out_valid1;
    logic [0:0]  rk_round1;
    logic [63:0] dout1;
    swan_pkg::state_t st1;

    // ROUNDS=32 instance
    logic        in_valid32 = 1'b0, rk_valid32 = 1'b0, out_ready32 = 1'b1;
    logic [63:0] din32 = '0;
    logic [31:0] rk32 = '0;
    logic        in_ready32, rk_req32, out_valid32;
    logic [4:0]  rk_round32;
    logic [63:0] dout32;
    swan_pkg::state_t st32;

    swan64_serial_round_ctrl #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .din(din1),
        .rk_req(rk_req1), .rk_round(rk_round1), .rk(rk1), .rk_valid(rk_valid1),
        .out_valid(out_valid1), .out_ready(out_ready1), .dout(dout1), .fsm_state(st1)
    );

    swan64_serial_round_ctrl #(.ROUNDS(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .din(din32),
        .rk_req(rk_req32), .rk_round(rk_round32), .rk(rk32), .rk_valid(rk_valid32),
        .out_valid(out_valid32), .out_ready(out_ready32), .dout(dout32), .fsm_state(st32)
    );

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] keys32 [0:31];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference theta with column rotates 7, 2, 1, 0 (column 0 = most significant byte).
    function automatic logic [31:0] m_theta(input logic [31:0] x, input logic [31:0] k);
        logic [31:0] y;
        logic [15:0] dbl;
        int          amt [0:3];
        amt[0] = 7; amt[1] = 2; amt[2] = 1; amt[3] = 0;
        for (int c = 0; c < 4; c++) begin
            dbl = {x[31-8*c -: 8], x[31-8*c -: 8]} >> amt[c];
            y[31-8*c -: 8] = dbl[7:0] ^ k[31-8*c -: 8];
        end
        return y;
    endfunction

    function automatic logic [63:0] model32(input logic [63:0] d);
        logic [31:0] l, r, nr;
        l = d[63:32];
        r = d[31:0];
        for (int i = 0; i < 32; i++) begin
            nr = l ^ m_theta(r, keys32[i]);
            l  = r;
            r  = nr;
        end
        return {l, r};
    endfunction

    // Drives one block into dut32, serving keys by rk_round, with up to 3 one-cycle
    // key stalls in distinct round ranges. lat counts cycles from accept to out_valid.
    task automatic run_block32(input logic [63:0] d, input int stalls, input bit hold_valid,
                               output logic [63:0] res, output int lat, output int mono_err);
        int  sr [0:2];
        bit  used [0:2];
        bit  have_prev, prev_valid;
        int  prev_round;
        sr[0] = $urandom_range(0, 9);
        sr[1] = $urandom_range(10, 20);
        sr[2] = $urandom_range(21, 31);
        for (int i = 0; i < 3; i++) used[i] = (i >= stalls);
        mono_err   = 0;
        have_prev  = 1'b0;
        prev_valid = 1'b0;
        prev_round = 0;
        din32      = d;
        in_valid32 = 1'b1;
        tick();
        lat = 1;
        if (!hold_valid) in_valid32 = 1'b0;
        while (!out_valid32 && lat < 200) begin
            if (rk_req32) begin
                if (have_prev) begin
                    if (prev_valid && int'(rk_round32) != prev_round + 1) mono_err++;
                    if (!prev_valid && int'(rk_round32) != prev_round) mono_err++;
                end
                rk32       = keys32[rk_round32];
                rk_valid32 = 1'b1;
                for (int i = 0; i < 3; i++)
                    if (!used[i] && int'(rk_round32) == sr[i]) begin
                        used[i]    = 1'b1;
                        rk_valid32 = 1'b0;
                    end
                have_prev  = 1'b1;
                prev_valid = rk_valid32;
                prev_round = int'(rk_round32);
            end
            tick();
            lat++;
        end
        rk_valid32 = 1'b0;
        res = dout32;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tests_run++;
        if ({in_ready32, rk_req32, rk_round32, out_valid32, dout32} !== {1'b1, 1'b0, 5'd0, 1'b0, 64'd0}) begin
            tests_failed++;
            $display("FAIL reset32: rdy=%b req=%b rnd=%0d ov=%b dout=%h, want 1 0 0 0 0",
                     in_ready32, rk_req32, rk_round32, out_valid32, dout32);
        end
        tests_run++;
        if ({in_ready1, rk_req1, rk_round1, out_valid1, dout1} !== {1'b1, 1'b0, 1'b0, 1'b0, 64'd0}) begin
            tests_failed++;
            $display("FAIL reset1: rdy=%b req=%b rnd=%0d ov=%b dout=%h, want 1 0 0 0 0",
                     in_ready1, rk_req1, rk_round1, out_valid1, dout1);
        end
        tests_run++;
        if (st32 !== swan_pkg::IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d want 0", st32);
        end
    endtask

    task automatic test_single_round(input string name, input logic [63:0] d,
                                     input logic [31:0] k, input logic [63:0] exp);
        int cyc;
        int bad_round;
        bad_round  = 0;
        rk1        = k;
        rk_valid1  = 1'b1;
        out_ready1 = 1'b1;
        din1       = d;
        in_valid1  = 1'b1;
        tick();
        cyc = 1;
        in_valid1 = 1'b0;
        while (!out_valid1 && cyc < 10) begin
            if (rk_req1 && rk_round1 !== 1'b0) bad_round++;
            tick();
            cyc++;
        end
        tests_run++;
        if (cyc != 2) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d want 2", name, cyc);
        end
        tests_run++;
        if (dout1 !== exp) begin
            tests_failed++;
            $display("FAIL %s_dout: got %h want %h", name, dout1, exp);
        end
        tests_run++;
        if (bad_round != 0) begin
            tests_failed++;
            $display("FAIL %s_rk_round: got %0d bad cycles want 0", name, bad_round);
        end
        tick();
        tests_run++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_one_cycle: ov=%b rdy=%b want 0 1", name, out_valid1, in_ready1);
        end
        rk_valid1 = 1'b0;
    endtask

    task automatic test_stall;
        logic [63:0] d, res;
        int lat, merr;
        d = {$urandom, $urandom};
        out_ready32 = 1'b1;
        run_block32(d, 3, 1'b0, res, lat, merr);
        tests_run++;
        if (lat != 36) begin
            tests_failed++;
            $display("FAIL stall_latency: got %0d want 36", lat);
        end
        tests_run++;
        if (res !== model32(d)) begin
            tests_failed++;
            $display("FAIL stall_dout: got %h want %h", res, model32(d));
        end
        tests_run++;
        if (merr != 0) begin
            tests_failed++;
            $display("FAIL stall_rk_round: got %0d step errors want 0", merr);
        end
        tick();
    endtask

    task automatic test_done_hold;
        logic [63:0] d, res;
        int lat, merr, bad;
        d = {$urandom, $urandom};
        out_ready32 = 1'b0;
        run_block32(d, 0, 1'b0, res, lat, merr);
        tests_run++;
        if (res !== model32(d) || lat != 33) begin
            tests_failed++;
            $display("FAIL hold_dout: got %h lat %0d want %h lat 33", res, lat, model32(d));
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                din32      = ~d;
                in_valid32 = 1'b1;
            end else begin
                in_valid32 = 1'b0;
            end
            tick();
            if (out_valid32 !== 1'b1 || dout32 !== res || in_ready32 !== 1'b0) bad++;
        end
        in_valid32 = 1'b0;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
        end
        out_ready32 = 1'b1;
        tick();
        tick();
        tests_run++;
        if (in_ready32 !== 1'b1 || rk_req32 !== 1'b0 || out_valid32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_ignored: rdy=%b req=%b ov=%b want 1 0 0",
                     in_ready32, rk_req32, out_valid32);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] d, res;
        int cyc, lat, merr;
        d = {$urandom, $urandom};
        din32      = d;
        in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        cyc = 0;
        while (!(rk_req32 && rk_round32 == 5'd10) && cyc < 50) begin
            rk32       = keys32[rk_round32];
            rk_valid32 = 1'b1;
            tick();
            cyc++;
        end
        tests_run++;
        if (rk_round32 !== 5'd10 || rk_req32 !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reach10: got req=%b rnd=%0d want 1 10", rk_req32, rk_round32);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rk_valid32 = 1'b0;
        tests_run++;
        if ({in_ready32, rk_req32, rk_round32, out_valid32, dout32} !== {1'b1, 1'b0, 5'd0, 1'b0, 64'd0}) begin
            tests_failed++;
            $display("FAIL mid_reset: rdy=%b req=%b rnd=%0d ov=%b dout=%h want 1 0 0 0 0",
                     in_ready32, rk_req32, rk_round32, out_valid32, dout32);
        end
        d = {$urandom, $urandom};
        run_block32(d, 1, 1'b0, res, lat, merr);
        tests_run++;
        if (res !== model32(d) || lat != 34 || merr != 0) begin
            tests_failed++;
            $display("FAIL mid_fresh: got %h lat %0d merr %0d want %h lat 34 merr 0",
                     res, lat, merr, model32(d));
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [63:0] a, b, res_a, res_b;
        int lat_a, lat_b, merr;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        out_ready32 = 1'b1;
        run_block32(a, 2, 1'b1, res_a, lat_a, merr);
        tests_run++;
        if (res_a !== model32(a) || lat_a != 35) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h lat %0d want %h lat 35", res_a, lat_a, model32(a));
        end
        din32 = b;
        tick();
        tests_run++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle_gap: rdy=%b ov=%b want 1 0", in_ready32, out_valid32);
        end
        run_block32(b, 0, 1'b0, res_b, lat_b, merr);
        tests_run++;
        if (res_b !== model32(b) || lat_b != 33) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h lat %0d want %h lat 33", res_b, lat_b, model32(b));
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) keys32[i] = $urandom;
        test_reset();
        test_single_round("zero_key", 64'h00000000_01010101, 32'h00000000, 64'h01010101_02408001);
        test_single_round("ones_key", 64'h00000000_01010101, 32'hFFFFFFFF, 64'h01010101_FDBF7FFE);
        test_stall();
        test_done_hold();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
